// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM states,
// latency counter width and the misalignment rule.
package data_mem_responder_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Reserved width code 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        if (width == MEM_HALF)
            return lo[0];
        else if (width == MEM_BYTE)
            return 1'b0;
        else
            return (lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational lane logic: load extract/extend and store byte-enable/lane replication.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  r_width,
    input  logic        r_signed,
    input  logic [1:0]  w_width,
    input  logic [31:0] w_data,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes
);

    logic [15:0] half;
    logic [7:0]  byt;

    always_comb begin
        half        = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        byt         = rd_word[{addr_lo, 3'b000} +: 8];
        load_data   = rd_word;
        byte_en     = 4'b1111;
        store_lanes = w_data;

        case (r_width)
            MEM_HALF: load_data = {{16{r_signed & half[15]}}, half};
            MEM_BYTE: load_data = {{24{r_signed & byt[7]}}, byt};
            default:  load_data = rd_word;
        endcase

        // Store data is replicated into every lane; byte_en picks the live ones.
        case (w_width)
            MEM_HALF: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{w_data[15:0]}};
            end
            MEM_BYTE: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{w_data[7:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                store_lanes = w_data;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: fixed-latency load/store with a one-cycle response pulse.
// Optional misaligned-access trap (adds Resp_Err) is enabled by defining MISALIGN_TRAP_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        R_Enable,
    input  logic        W_Enable,
    input  logic [1:0]  R_Width,
    input  logic [1:0]  W_Width,
    input  logic        R_Signed,
    input  logic [31:0] Address,
    input  logic [31:0] W_Data,
    output logic [31:0] R_Data,
    output logic        Resp_Valid
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        Resp_Err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;

    logic          q_r_en, q_w_en, q_r_signed;
    logic [1:0]    q_r_width, q_w_width;
    logic [AW+1:0] q_addr;
    logic [31:0]   q_w_data;

    logic          c_r_en, c_w_en, c_r_signed;
    logic [1:0]    c_r_width, c_w_width;
    logic [AW+1:0] c_addr;
    logic [31:0]   c_w_data;

    logic        accept, enter_resp, misalign;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word, load_data, store_lanes;
    logic [3:0]  byte_en;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^Address[31:AW+2];

    assign Req_Ready  = (state == ST_IDLE) && !Reset;
    assign accept     = Req_Valid && Req_Ready;
    assign Resp_Valid = (state == ST_RESP);

    // With LATENCY==1 the commit edge is the accept edge, so the live request is
    // used in IDLE; otherwise the fields latched at acceptance drive the access.
    always_comb begin
        if (state == ST_IDLE) begin
            c_r_en     = R_Enable;
            c_w_en     = W_Enable;
            c_r_width  = R_Width;
            c_w_width  = W_Width;
            c_r_signed = R_Signed;
            c_addr     = Address[AW+1:0];
            c_w_data   = W_Data;
        end else begin
            c_r_en     = q_r_en;
            c_w_en     = q_w_en;
            c_r_width  = q_r_width;
            c_w_width  = q_w_width;
            c_r_signed = q_r_signed;
            c_addr     = q_addr;
            c_w_data   = q_w_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = (c_r_en && is_misaligned(c_r_width, c_addr[1:0]))
                   || (c_w_en && is_misaligned(c_w_width, c_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign rd_word = mem[c_addr[AW+1:2]];

    mem_lane_align u_align (
        .rd_word     (rd_word),
        .addr_lo     (c_addr[1:0]),
        .r_width     (c_r_width),
        .r_signed    (c_r_signed),
        .w_width     (c_w_width),
        .w_data      (c_w_data),
        .load_data   (load_data),
        .byte_en     (byte_en),
        .store_lanes (store_lanes)
    );

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == WAIT_LAST) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_next == ST_RESP) && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt    <= '0;
            R_Data <= '0;
        end else begin
            if (state == ST_WAIT)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            if (accept) begin
                q_r_en     <= R_Enable;
                q_w_en     <= W_Enable;
                q_r_width  <= R_Width;
                q_w_width  <= W_Width;
                q_r_signed <= R_Signed;
                q_addr     <= Address[AW+1:0];
                q_w_data   <= W_Data;
            end
            if (enter_resp)
                R_Data <= (c_r_en && !misalign) ? load_data : '0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    always_ff @(posedge Clock) begin
        if (Reset)
            err_q <= 1'b0;
        else if (enter_resp)
            err_q <= misalign;
    end
    assign Resp_Err = Resp_Valid && err_q;
`endif

    // RAM array is not reset; the non-blocking write keeps load-before-store ordering.
    always_ff @(posedge Clock) begin
        if (enter_resp && c_w_en && !misalign) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[c_addr[AW+1:2]][8*b +: 8] <= store_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// accesses compared against a byte-level reference memory.
module tb_data_mem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 1024;

    logic        Clock, Reset, Req_Valid, Req_Ready;
    logic        R_Enable, W_Enable, R_Signed;
    logic [1:0]  R_Width, W_Width;
    logic [31:0] Address, W_Data, R_Data;
    logic        Resp_Valid;
`ifdef MISALIGN_TRAP_EN
    logic        Resp_Err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .R_Enable   (R_Enable),
        .W_Enable   (W_Enable),
        .R_Width    (R_Width),
        .W_Width    (W_Width),
        .R_Signed   (R_Signed),
        .Address    (Address),
        .W_Data     (W_Data),
        .R_Data     (R_Data),
        .Resp_Valid (Resp_Valid)
`ifdef MISALIGN_TRAP_EN
        ,
        .Resp_Err   (Resp_Err)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit tb_misaligned(input logic [1:0] wd, input int unsigned lo);
        if (wd == 2'd1) return (lo % 2) != 0;
        if (wd == 2'd2) return 1'b0;
        return lo != 0;
    endfunction

    // Reference: word = little-endian byte array; loads shift/extend, stores replace bytes.
    task automatic model_access(input logic re, input logic we, input logic [1:0] rw,
                                input logic [1:0] ww, input logic rs,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_data, output logic exp_err);
        int unsigned idx, lo, start, size;
        logic [31:0] w, v;
        idx = (addr / 4) % DEPTH;
        lo  = addr % 4;
        w   = ref_mem[idx];
        exp_err = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (re && tb_misaligned(rw, lo)) exp_err = 1'b1;
        if (we && tb_misaligned(ww, lo)) exp_err = 1'b1;
`endif
        exp_data = 32'h0;
        if (re && !exp_err) begin
            case (rw)
                2'd1: begin
                    v = (w >> ((lo / 2) * 16)) & 32'hFFFF;
                    if (rs && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end
                2'd2: begin
                    v = (w >> (lo * 8)) & 32'hFF;
                    if (rs && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end
                default: v = w;
            endcase
            exp_data = v;
        end
        if (we && !exp_err) begin
            case (ww)
                2'd1:    begin start = (lo / 2) * 2; size = 2; end
                2'd2:    begin start = lo;           size = 1; end
                default: begin start = 0;            size = 4; end
            endcase
            for (int unsigned b = 0; b < size; b++)
                w[8*(start+b) +: 8] = wdata[8*b +: 8];
            ref_mem[idx] = w;
        end
    endtask

    task automatic do_req(input string tag, input logic re, input logic we,
                          input logic [1:0] rw, input logic [1:0] ww, input logic rs,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_data;
        logic        exp_err;
        int          n;
        model_access(re, we, rw, ww, rs, addr, wdata, exp_data, exp_err);
        @(negedge Clock);
        R_Enable = re; W_Enable = we; R_Width = rw; W_Width = ww; R_Signed = rs;
        Address = addr; W_Data = wdata; Req_Valid = 1'b1;
        n = 0;
        while (!Req_Ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!Req_Ready) begin
            check({tag, " ready timeout"}, 32'(Req_Ready), 32'd1);
            Req_Valid = 1'b0;
            return;
        end
        @(posedge Clock);
        #1;
        // Scramble the bus after acceptance: the responder must use latched fields.
        Req_Valid = 1'b0;
        R_Enable = 1'($urandom); W_Enable = 1'($urandom);
        R_Width = 2'($urandom); W_Width = 2'($urandom); R_Signed = 1'($urandom);
        Address = $urandom; W_Data = $urandom;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!Resp_Valid && n < 20);
        check({tag, " latency"}, 32'(n), 32'(LATENCY));
        check({tag, " rdata"}, R_Data, exp_data);
`ifdef MISALIGN_TRAP_EN
        check({tag, " err"}, 32'(Resp_Err), 32'(exp_err));
`endif
        @(negedge Clock);
        check({tag, " pulse end"}, 32'(Resp_Valid), 32'd0);
        check({tag, " rdata hold"}, R_Data, exp_data);
    endtask

    initial begin
        int acc, rsp;
        Reset = 1'b1; Req_Valid = 1'b0; R_Enable = 1'b0; W_Enable = 1'b0;
        R_Width = 2'd0; W_Width = 2'd0; R_Signed = 1'b0; Address = '0; W_Data = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset resp_valid", 32'(Resp_Valid), 32'd0);
        check("reset rdata", R_Data, 32'd0);
        check("reset ready low", 32'(Req_Ready), 32'd0);
        Reset = 1'b0;
        #1;
        check("ready after reset", 32'(Req_Ready), 32'd1);

        // word store then load
        do_req("sw 0x10", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req("lw 0x10", 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h0);

        // byte store into a known word, then word / signed / unsigned byte loads
        do_req("sw base", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h10, 32'h1122_3344);
        do_req("sb 0x13", 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 32'h13, 32'h0000_00AA);
        do_req("lw merged", 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h0);
        do_req("lb 0x13", 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 32'h13, 32'h0);
        do_req("lbu 0x13", 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 32'h13, 32'h0);

        // half store over zero, signed / unsigned half loads
        do_req("sw zero", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h20, 32'h0);
        do_req("sh 0x22", 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 32'h22, 32'h0000_8001);
        do_req("lh 0x22", 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 32'h22, 32'h0);
        do_req("lhu 0x22", 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 32'h22, 32'h0);

        // read-before-write and no-enable request
        do_req("rmw", 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 32'h20, 32'h0BAD_F00D);
        do_req("no enable", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 32'h20, 32'hFFFF_FFFF);
        do_req("lw after rmw", 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h20, 32'h0);

        // Req_Valid held high: one accept per LATENCY+1 cycles, no duplicates
        @(negedge Clock);
        R_Enable = 1'b0; W_Enable = 1'b0; Address = $urandom; Req_Valid = 1'b1;
        acc = 0; rsp = 0;
        for (int i = 0; i < 30; i++) begin
            if (Req_Ready) acc++;
            if (Resp_Valid) begin
                rsp++;
                check("stream ready in resp", 32'(Req_Ready), 32'd0);
                check("stream rdata", R_Data, 32'd0);
            end
            @(negedge Clock);
        end
        Req_Valid = 1'b0;
        check("stream accepts", 32'(acc), 32'(30 / (LATENCY + 1)));
        check("stream responses", 32'(rsp), 32'(30 / (LATENCY + 1)));

        // misaligned word store: trapped when enabled, aligned-down otherwise
        do_req("sw 0x0 zero", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);
        do_req("sw 0x2", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h2, 32'hCAFE_F00D);
        do_req("lw 0x0 after sw 0x2", 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);

        // reset while a store waits: dropped, no response, memory untouched
        do_req("sw 0x0 clear", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge Clock);
        R_Enable = 1'b0; W_Enable = 1'b1; W_Width = 2'd0; Address = 32'h0;
        W_Data = 32'h55; Req_Valid = 1'b1;
        @(posedge Clock);
        #1 Req_Valid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        rsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (Resp_Valid) rsp++;
        end
        check("reset drop no resp", 32'(rsp), 32'd0);
        check("reset drop rdata", R_Data, 32'd0);
        do_req("lw 0x0 after drop", 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0);

        // randomized traffic over 16 words, with random upper address bits to exercise wrap
        for (int i = 0; i < 16; i++)
            do_req("init", 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, ($urandom & 32'hFFFF_F000) | 32'(i * 4), $urandom);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_req("rand", 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
